ram_bank_2r1w: RTL and testbench

Parametrised DEPTH x WIDTH register-file RAM with one write port and two independent read ports. It is the multi-row successor to the single-row RAM cell array and holds the CPU data and register storage. New relative to the single-row block:
- registered reads with valid flags
- optional write-to-read bypass
- address range checking
- a synchronous clear sequencer that zeroes the array without a reset
- a debug row tap

---
 rtl/ram_bank_pkg.sv | 18 +
 rtl/ram_bank_clear_fsm.sv | 61 ++++++
 rtl/ram_bank_2r1w.sv | 141 ++++++++++++++
 tb/tb_ram_bank_2r1w.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bank_pkg.sv
// rtl/ram_bank_pkg.sv - shared types, default sizes and helpers for the 2R1W register-file RAM
package ram_bank_pkg;

   // Clear sequencer states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

   localparam int RAM_WIDTH = 11;
   localparam int RAM_DEPTH = 16;

   // Address width for a given row count; never narrower than one bit
   function automatic int addr_width(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ram_bank_clear_fsm.sv
// rtl/ram_bank_clear_fsm.sv - sequencer that walks every row writing zero, one row per cycle
module ram_bank_clear_fsm
   import ram_bank_pkg::*;
#(
   parameter int DEPTH  = RAM_DEPTH,
   parameter int ADDR_W = addr_width(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              clr_req_i,
   output logic              idle_o,
   output logic              busy_o,
   output logic              clr_we_o,
   output logic [ADDR_W-1:0] clr_addr_o
);

   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

   clr_state_e        state_q;
   logic [ADDR_W-1:0] ptr_q;
   logic              busy_q;

   // State, row pointer and busy flag advance together; requests are ignored mid-clear
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_req_i) begin
                  state_q <= ST_CLEAR;
                  ptr_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            ST_CLEAR: begin
               if (ptr_q == LAST_ROW) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  ptr_q <= ptr_q + ADDR_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ptr_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign idle_o     = (state_q == ST_IDLE);
   assign busy_o     = busy_q;
   assign clr_we_o   = (state_q == ST_CLEAR);
   assign clr_addr_o = ptr_q;

endmodule

// File: rtl/ram_bank_2r1w.sv
// rtl/ram_bank_2r1w.sv - DEPTH x WIDTH register-file RAM, one write port, two registered read ports
module ram_bank_2r1w
   import ram_bank_pkg::*;
#(
   parameter int   WIDTH  = RAM_WIDTH,
   parameter int   DEPTH  = RAM_DEPTH,
   parameter bit   BYPASS = 1'b1,
   localparam int  ADDR_W = addr_width(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]  wr_data_i,
   output logic              wr_ack_o,
   input  logic              rd_en_1_i,
   input  logic [ADDR_W-1:0] rd_addr_1_i,
   output logic [WIDTH-1:0]  rd_data_1_o,
   output logic              rd_valid_1_o,
   input  logic              rd_en_2_i,
   input  logic [ADDR_W-1:0] rd_addr_2_i,
   output logic [WIDTH-1:0]  rd_data_2_o,
   output logic              rd_valid_2_o,
   input  logic              clr_req_i,
   output logic              busy_o,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic [WIDTH-1:0]  dbg_row_data_o
);

   // True when the address names an existing row (DEPTH need not be a power of two)
   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
   endfunction

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              fsm_idle;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   logic              wr_accept;
   logic              arr_we;
   logic [ADDR_W-1:0] arr_addr;
   logic [WIDTH-1:0]  arr_data;

   logic [WIDTH-1:0]  rd_data_1_d, rd_data_1_q;
   logic [WIDTH-1:0]  rd_data_2_d, rd_data_2_q;
   logic              rd_valid_1_q, rd_valid_2_q;
   logic              wr_ack_q;

   ram_bank_clear_fsm #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clear_fsm (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_req_i  (clr_req_i),
      .idle_o     (fsm_idle),
      .busy_o     (busy_o),
      .clr_we_o   (clr_we),
      .clr_addr_o (clr_addr)
   );

   // A clear request on the same edge takes priority over a user write
   assign wr_accept = wr_en_i && fsm_idle && !clr_req_i && in_range(wr_addr_i);

   // Single array write port shared by the sequencer and the user
   always_comb begin
      arr_we   = clr_we || wr_accept;
      arr_addr = clr_we ? clr_addr : wr_addr_i;
      arr_data = clr_we ? '0 : wr_data_i;
   end

   // Row storage; cleared asynchronously by reset, otherwise one row per edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (arr_we) begin
         mem_q[arr_addr] <= arr_data;
      end
   end

   // Port 1 read value, with optional forwarding of the row being written this edge
   always_comb begin
      rd_data_1_d = '0;
      if (in_range(rd_addr_1_i)) begin
         rd_data_1_d = mem_q[rd_addr_1_i];
         if (BYPASS && arr_we && (arr_addr == rd_addr_1_i)) begin
            rd_data_1_d = arr_data;
         end
      end
   end

   // Port 2 read value, same rules as port 1
   always_comb begin
      rd_data_2_d = '0;
      if (in_range(rd_addr_2_i)) begin
         rd_data_2_d = mem_q[rd_addr_2_i];
         if (BYPASS && arr_we && (arr_addr == rd_addr_2_i)) begin
            rd_data_2_d = arr_data;
         end
      end
   end

   // Read registers: data holds between requests, valid pulses one cycle per request
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_1_q  <= '0;
         rd_data_2_q  <= '0;
         rd_valid_1_q <= 1'b0;
         rd_valid_2_q <= 1'b0;
      end else begin
         rd_valid_1_q <= rd_en_1_i;
         rd_valid_2_q <= rd_en_2_i;
         if (rd_en_1_i) begin
            rd_data_1_q <= rd_data_1_d;
         end
         if (rd_en_2_i) begin
            rd_data_2_q <= rd_data_2_d;
         end
      end
   end

   // Write acknowledge one cycle after an accepted write
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ack_q <= 1'b0;
      end else begin
         wr_ack_q <= wr_accept;
      end
   end

   assign wr_ack_o       = wr_ack_q;
   assign rd_data_1_o    = rd_data_1_q;
   assign rd_data_2_o    = rd_data_2_q;
   assign rd_valid_1_o   = rd_valid_1_q;
   assign rd_valid_2_o   = rd_valid_2_q;
   assign dbg_row_data_o = in_range(dbg_addr_i) ? mem_q[dbg_addr_i] : '0;

endmodule

// File: tb/tb_ram_bank_2r1w.sv
// tb/tb_ram_bank_2r1w.sv - self-checking bench for the 2R1W register-file RAM
module tb_ram_bank_2r1w;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // DUT A: DEPTH 16, BYPASS 1
   logic        a_wr_en, a_wr_ack, a_rd_en_1, a_rd_valid_1, a_rd_en_2, a_rd_valid_2, a_clr_req, a_busy;
   logic [3:0]  a_wr_addr, a_rd_addr_1, a_rd_addr_2, a_dbg_addr;
   logic [10:0] a_wr_data, a_rd_data_1, a_rd_data_2, a_dbg_row_data;

   // DUT B: DEPTH 12, BYPASS 0
   logic        b_wr_en, b_wr_ack, b_rd_en_1, b_rd_valid_1, b_rd_en_2, b_rd_valid_2, b_clr_req, b_busy;
   logic [3:0]  b_wr_addr, b_rd_addr_1, b_rd_addr_2, b_dbg_addr;
   logic [10:0] b_wr_data, b_rd_data_1, b_rd_data_2, b_dbg_row_data;

   int checks   = 0;
   int failures = 0;

   ram_bank_2r1w #(.WIDTH(11), .DEPTH(16), .BYPASS(1'b1)) u_a (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data), .wr_ack_o(a_wr_ack),
      .rd_en_1_i(a_rd_en_1), .rd_addr_1_i(a_rd_addr_1), .rd_data_1_o(a_rd_data_1), .rd_valid_1_o(a_rd_valid_1),
      .rd_en_2_i(a_rd_en_2), .rd_addr_2_i(a_rd_addr_2), .rd_data_2_o(a_rd_data_2), .rd_valid_2_o(a_rd_valid_2),
      .clr_req_i(a_clr_req), .busy_o(a_busy), .dbg_addr_i(a_dbg_addr), .dbg_row_data_o(a_dbg_row_data)
   );

   ram_bank_2r1w #(.WIDTH(11), .DEPTH(12), .BYPASS(1'b0)) u_b (
      .clk_i(clk), .rst_ni(rst_n),
      .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data), .wr_ack_o(b_wr_ack),
      .rd_en_1_i(b_rd_en_1), .rd_addr_1_i(b_rd_addr_1), .rd_data_1_o(b_rd_data_1), .rd_valid_1_o(b_rd_valid_1),
      .rd_en_2_i(b_rd_en_2), .rd_addr_2_i(b_rd_addr_2), .rd_data_2_o(b_rd_data_2), .rd_valid_2_o(b_rd_valid_2),
      .clr_req_i(b_clr_req), .busy_o(b_busy), .dbg_addr_i(b_dbg_addr), .dbg_row_data_o(b_dbg_row_data)
   );

   typedef struct {
      logic        wr_en;
      logic [3:0]  wr_addr;
      logic [10:0] wr_data;
      logic        rd_en_1;
      logic [3:0]  rd_addr_1;
      logic        rd_en_2;
      logic [3:0]  rd_addr_2;
      logic [3:0]  dbg_addr;
      logic        ack;
      logic        v1;
      logic [10:0] d1;
      logic        v2;
      logic [10:0] d2;
      logic [10:0] dbg;
   } vec_t;

   typedef struct {
      logic        ack;
      logic        v1;
      logic [10:0] d1;
      logic        v2;
      logic [10:0] d2;
      logic [10:0] dbg;
   } exp_t;

   vec_t vecs [8];
   exp_t sb [$];

   function automatic vec_t mk(input int we, input int wa, input int wd, input int r1, input int a1,
                               input int r2, input int a2, input int da, input int ack, input int v1,
                               input int d1, input int v2, input int d2, input int dv);
      vec_t v;
      v.wr_en = 1'(we);   v.wr_addr = 4'(wa);   v.wr_data = 11'(wd);
      v.rd_en_1 = 1'(r1); v.rd_addr_1 = 4'(a1); v.rd_en_2 = 1'(r2); v.rd_addr_2 = 4'(a2);
      v.dbg_addr = 4'(da);
      v.ack = 1'(ack); v.v1 = 1'(v1); v.d1 = 11'(d1); v.v2 = 1'(v2); v.d2 = 11'(d2); v.dbg = 11'(dv);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic a_idle();
      a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
      a_rd_en_1 = 1'b0; a_rd_addr_1 = '0; a_rd_en_2 = 1'b0; a_rd_addr_2 = '0;
      a_clr_req = 1'b0;
   endtask

   task automatic b_idle();
      b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
      b_rd_en_1 = 1'b0; b_rd_addr_1 = '0; b_rd_en_2 = 1'b0; b_rd_addr_2 = '0;
      b_clr_req = 1'b0;
   endtask

   // Starts and ends on a falling edge
   task automatic a_fill(input logic [10:0] val);
      for (int r = 0; r < 16; r++) begin
         a_wr_en = 1'b1; a_wr_addr = 4'(r); a_wr_data = val;
         @(posedge clk); #1;
         chk("fill_ack", 32'(a_wr_ack), 32'd1);
         @(negedge clk);
      end
      a_idle();
   endtask

   task automatic a_rows_zero(input string name);
      for (int r = 0; r < 16; r++) begin
         a_dbg_addr = 4'(r); #1;
         chk(name, 32'(a_dbg_row_data), 32'd0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   busy_cycles;
      int   p;

      vecs[0] = mk(1, 3, 'h5A5,  0, 0,  0, 0,  3,  1, 0, 'h000, 0, 'h000, 'h5A5);
      vecs[1] = mk(0, 0, 0,      1, 3,  0, 0,  0,  0, 1, 'h5A5, 0, 'h000, 'h000);
      vecs[2] = mk(1, 5, 'h001,  0, 0,  1, 3,  5,  1, 0, 'h5A5, 1, 'h5A5, 'h001);
      vecs[3] = mk(1, 5, 'h7FF,  0, 0,  1, 5,  5,  1, 0, 'h5A5, 1, 'h7FF, 'h7FF);
      vecs[4] = mk(0, 0, 0,      1, 5,  1, 5,  3,  0, 1, 'h7FF, 1, 'h7FF, 'h5A5);
      vecs[5] = mk(0, 0, 0,      1, 0,  0, 0,  0,  0, 1, 'h000, 0, 'h7FF, 'h000);
      vecs[6] = mk(1, 15, 'h2AA, 1, 15, 0, 0,  15, 1, 1, 'h2AA, 0, 'h7FF, 'h2AA);
      vecs[7] = mk(0, 0, 0,      0, 0,  1, 15, 15, 0, 0, 'h2AA, 1, 'h2AA, 'h2AA);

      rst_n = 1'b0;
      a_idle(); b_idle();
      a_dbg_addr = '0; b_dbg_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_valid1", 32'(a_rd_valid_1), 32'd0);
      chk("rst_valid2", 32'(a_rd_valid_2), 32'd0);
      chk("rst_data1", 32'(a_rd_data_1), 32'd0);
      chk("rst_ack", 32'(a_wr_ack), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      a_rows_zero("rst_row_zero");
      @(negedge clk);

      // Table-driven single-cycle vectors on DUT A
      for (int i = 0; i < 8; i++) begin
         a_wr_en = vecs[i].wr_en; a_wr_addr = vecs[i].wr_addr; a_wr_data = vecs[i].wr_data;
         a_rd_en_1 = vecs[i].rd_en_1; a_rd_addr_1 = vecs[i].rd_addr_1;
         a_rd_en_2 = vecs[i].rd_en_2; a_rd_addr_2 = vecs[i].rd_addr_2;
         a_dbg_addr = vecs[i].dbg_addr;
         e.ack = vecs[i].ack; e.v1 = vecs[i].v1; e.d1 = vecs[i].d1;
         e.v2 = vecs[i].v2;   e.d2 = vecs[i].d2; e.dbg = vecs[i].dbg;
         sb.push_back(e);
         @(posedge clk); #1;
         if (sb.size() == 0) begin
            chk("vec_scoreboard_empty", 32'd0, 32'd1);
         end else begin
            e = sb.pop_front();
            chk($sformatf("vec%0d_ack", i), 32'(a_wr_ack), 32'(e.ack));
            chk($sformatf("vec%0d_valid1", i), 32'(a_rd_valid_1), 32'(e.v1));
            chk($sformatf("vec%0d_data1", i), 32'(a_rd_data_1), 32'(e.d1));
            chk($sformatf("vec%0d_valid2", i), 32'(a_rd_valid_2), 32'(e.v2));
            chk($sformatf("vec%0d_data2", i), 32'(a_rd_data_2), 32'(e.d2));
            chk($sformatf("vec%0d_dbg", i), 32'(a_dbg_row_data), 32'(e.dbg));
         end
         @(negedge clk);
      end
      a_idle();

      // Full clear: clr_req and a write on the same edge, clear wins
      a_fill(11'h3C3);
      a_clr_req = 1'b1; a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 11'h111;
      @(posedge clk); #1;
      chk("clr_same_edge_ack", 32'(a_wr_ack), 32'd0);
      chk("clr_busy_rise", 32'(a_busy), 32'd1);
      @(negedge clk);
      a_idle();
      busy_cycles = 0;
      while (a_busy === 1'b1 && busy_cycles < 40) begin
         p = busy_cycles;
         a_rd_en_1 = 1'b1; a_rd_addr_1 = 4'd15;
         a_wr_en = (p == 2); a_wr_addr = 4'd0; a_wr_data = 11'h123;
         a_clr_req = (p == 3);
         @(posedge clk); #1;
         chk("clr_rd_valid", 32'(a_rd_valid_1), 32'd1);
         chk("clr_rd_data", 32'(a_rd_data_1), (p == 15) ? 32'd0 : 32'h3C3);
         if (p == 2) chk("clr_mid_write_ack", 32'(a_wr_ack), 32'd0);
         busy_cycles++;
         @(negedge clk);
         a_idle();
      end
      chk("clr_busy_cycles", 32'(busy_cycles), 32'd16);
      a_rows_zero("clr_row_zero");
      @(negedge clk);

      // Reset during clear cycle 7
      a_fill(11'h3C3);
      a_clr_req = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      a_idle();
      repeat (7) begin
         @(posedge clk); #1;
         @(negedge clk);
      end
      a_dbg_addr = 4'd10; #1;
      chk("midclr_row10_pending", 32'(a_dbg_row_data), 32'h3C3);
      rst_n = 1'b0; #1;
      chk("midclr_busy_drop", 32'(a_busy), 32'd0);
      a_rows_zero("midclr_row_zero");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Next clear restarts from row 0
      a_fill(11'h3C3);
      a_clr_req = 1'b1;
      @(posedge clk); #1;
      chk("restart_busy", 32'(a_busy), 32'd1);
      @(negedge clk);
      a_idle();
      @(posedge clk); #1;
      a_dbg_addr = 4'd0; #1;
      chk("restart_row0", 32'(a_dbg_row_data), 32'd0);
      a_dbg_addr = 4'd1; #1;
      chk("restart_row1", 32'(a_dbg_row_data), 32'h3C3);
      @(negedge clk);
      busy_cycles = 1;
      while (a_busy === 1'b1 && busy_cycles < 40) begin
         @(posedge clk); #1;
         busy_cycles++;
         @(negedge clk);
      end
      chk("restart_busy_cycles", 32'(busy_cycles), 32'd16);

      // DUT B: DEPTH 12 range checks and BYPASS 0 collision
      b_wr_en = 1'b1; b_wr_addr = 4'd13; b_wr_data = 11'h155; b_dbg_addr = 4'd13;
      @(posedge clk); #1;
      chk("b_oor_write_ack", 32'(b_wr_ack), 32'd0);
      chk("b_oor_dbg", 32'(b_dbg_row_data), 32'd0);
      @(negedge clk);
      b_wr_addr = 4'd11; b_wr_data = 11'h001; b_dbg_addr = 4'd11;
      @(posedge clk); #1;
      chk("b_last_row_ack", 32'(b_wr_ack), 32'd1);
      chk("b_last_row_dbg", 32'(b_dbg_row_data), 32'h001);
      @(negedge clk);
      b_idle();
      b_rd_en_1 = 1'b1; b_rd_addr_1 = 4'd11;
      @(posedge clk); #1;
      chk("b_rd_last_data", 32'(b_rd_data_1), 32'h001);
      @(negedge clk);
      b_rd_addr_1 = 4'd13;
      @(posedge clk); #1;
      chk("b_rd_oor_valid", 32'(b_rd_valid_1), 32'd1);
      chk("b_rd_oor_data", 32'(b_rd_data_1), 32'd0);
      @(negedge clk);
      b_idle();
      b_wr_en = 1'b1; b_wr_addr = 4'd11; b_wr_data = 11'h7FF;
      b_rd_en_2 = 1'b1; b_rd_addr_2 = 4'd11;
      @(posedge clk); #1;
      chk("b_nobypass_data2", 32'(b_rd_data_2), 32'h001);
      chk("b_nobypass_valid2", 32'(b_rd_valid_2), 32'd1);
      chk("b_nobypass_row", 32'(b_dbg_row_data), 32'h7FF);
      @(negedge clk);
      b_idle();
      b_clr_req = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      b_idle();
      busy_cycles = 0;
      while (b_busy === 1'b1 && busy_cycles < 40) begin
         @(posedge clk); #1;
         busy_cycles++;
         @(negedge clk);
      end
      chk("b_busy_cycles", 32'(busy_cycles), 32'd12);
      chk("b_row11_cleared", 32'(b_dbg_row_data), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
